mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
- Memory-to-writeback pipeline register plus writeback stage of the 5-stage MIPS pipeline.
- Latches MEM-stage results and extracts/extends load data by width.
- Selects the ALU result or the load result, then drives the register-file write port that Instruction_Decode consumes: RegDestSelected_WB, regWriteData_WB, regWrite_WB.
- Handles pipeline stall and flush. Optionally counts retired instructions.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter (used only with RETIRE_COUNTER_EN).
- SUPPRESS_R0, 1, when 1 a write targeting register 0 is retired with regWrite_WB forced to 0.

Ports:
- Clock  in  1  global clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall_MEM  in  1  hold the WB register contents.
- Flush_MEM  in  1  load a bubble instead of MEM inputs.
- Valid_MEM  in  1  MEM slot holds a real instruction.
- RegWrite_MEM  in  1  instruction writes the register file.
- MemToReg_MEM  in  1  1 = load data, 0 = ALU result.
- R_Width_MEM  in  2  load width: 00 word, 01 half, 10 byte, 11 treated as word.
- LoadSigned_MEM  in  1  1 = sign-extend, 0 = zero-extend sub-word loads.
- ByteAddr_MEM  in  2  low address bits of the load.
- ALUResult_MEM  in  32  ALU result.
- MemReadData_MEM  in  32  raw data-memory word.
- RegDestSelected_MEM  in  5  destination register.
- RegDestSelected_WB  out  5  register-file write address.
- regWriteData_WB  out  32  register-file write data.
- regWrite_WB  out  1  register-file write enable.
- Valid_WB  out  1  WB slot holds a real instruction.
- RetireCount  out  COUNT_WIDTH  retired-instruction count (only with RETIRE_COUNTER_EN).

Behaviour:
- Reset low, asynchronous: all outputs 0 immediately; they stay 0 until the first rising edge after release.
- Latency: exactly 1 cycle from MEM inputs to WB outputs. Data extraction and selection occur before the register, so WB outputs are pure flops.
- Per rising edge, priority is Reset > Flush_MEM > Stall_MEM > load.
  - Flush: bubble loaded: Valid_WB=0, regWrite_WB=0, RegDestSelected_WB=0, regWriteData_WB=0. Flush wins over a simultaneous Stall.
  - Stall: all outputs hold their previous values, including regWrite_WB. The register file is rewritten with the same value, which is harmless by design.
  - Load: Valid_WB=Valid_MEM; regWrite_WB=RegWrite_MEM & Valid_MEM & !(SUPPRESS_R0 && RegDestSelected_MEM==0).
  - RegDestSelected_WB takes RegDestSelected_MEM whenever Valid_MEM=1, otherwise 0.
- Load extraction, lane 0 = bits[7:0]:
  - Byte: lane = ByteAddr_MEM, value = MemReadData_MEM[8*lane+7 : 8*lane].
  - Half: ByteAddr_MEM[1]=0 selects [15:0], 1 selects [31:16]. ByteAddr_MEM[0] is ignored (no misalignment trap).
  - Word/11: full word; ByteAddr_MEM is ignored.
  - Extension to 32 bits: sign bit replicated if LoadSigned_MEM=1, else zeros.
- regWriteData_WB = MemToReg_MEM ? extracted load : ALUResult_MEM. The value is loaded even when regWrite is 0, except on bubble (Valid_MEM=0 or flush), where it is 0.
- No internal state other than the WB register and the optional counter. There is no FSM.

Optional Feature:
- Macro: RETIRE_COUNTER_EN.
- Defined:
  - RetireCount port exists and resets to 0.
  - Increments by 1 on each edge that performs a load with Valid_MEM=1 (not on stall, not on flush).
  - Wraps modulo 2^COUNT_WIDTH.
  - Counts valid instructions even when regWrite is suppressed (stores, branches, writes to r0).
- Undefined: port and counter logic absent; all other behaviour identical.

Test Plan:
- Reset=0 mid-operation with regWrite_WB=1 -> all outputs 0 at once without a clock edge; first valid load after release appears 1 cycle later.
- ALU write: Valid=1, RegWrite=1, MemToReg=0, ALUResult=0x0000_1234, dest=8 -> next cycle regWrite_WB=1, RegDestSelected_WB=8, regWriteData_WB=0x0000_1234.
- Loads with MemReadData=0x80FF_7F01, MemToReg=1:
  - byte, signed, ByteAddr=3 -> 0xFFFF_FF80;
  - byte, unsigned, ByteAddr=1 -> 0x0000_007F;
  - half, signed, ByteAddr=2 -> 0xFFFF_80FF;
  - half, unsigned, ByteAddr=0 -> 0x0000_7F01;
  - word -> 0x80FF_7F01.
- r0 write: dest=0, RegWrite=1, SUPPRESS_R0=1 -> regWrite_WB=0, Valid_WB=1.
- Stall/flush: load dest=5 data=0xA, then Stall=1 for 3 cycles with changing inputs -> outputs hold 5/0xA/1; then Stall=1 and Flush=1 together -> bubble (all 0, Valid_WB=0).
- RETIRE_COUNTER_EN, COUNT_WIDTH=4:
  - 10 valid loads, 2 stalls, 1 flush -> RetireCount=10.
  - 6 more valid loads -> RetireCount wraps to 0.

Source files
------------

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register plus writeback: extracts/extends load data, selects the result, drives the regfile write port.
// Latency: 1 cycle from MEM inputs to WB outputs; all WB outputs come straight from flops.
// Backpressure: Stall_MEM holds the WB register, Flush_MEM loads a bubble (flush wins). Optional RETIRE_COUNTER_EN adds RetireCount.
module mem_wb_writeback #(
    parameter int COUNT_WIDTH = 32,
    parameter bit SUPPRESS_R0 = 1'b1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Stall_MEM,
    input  logic                   Flush_MEM,
    input  logic                   Valid_MEM,
    input  logic                   RegWrite_MEM,
    input  logic                   MemToReg_MEM,
    input  logic [1:0]             R_Width_MEM,
    input  logic                   LoadSigned_MEM,
    input  logic [1:0]             ByteAddr_MEM,
    input  logic [31:0]            ALUResult_MEM,
    input  logic [31:0]            MemReadData_MEM,
    input  logic [4:0]             RegDestSelected_MEM,
    output logic [4:0]             RegDestSelected_WB,
    output logic [31:0]            regWriteData_WB,
    output logic                   regWrite_WB,
    output logic                   Valid_WB
`ifdef RETIRE_COUNTER_EN
    ,
    output logic [COUNT_WIDTH-1:0] RetireCount
`endif
);

    // Everything the WB stage presents to the register file, kept as one word.
    typedef struct packed {
        logic        vld;
        logic        wr;
        logic [4:0]  dest;
        logic [31:0] dat;
    } wb_t;

    wb_t         wb_q;
    wb_t         wb_nxt;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    // Pick the addressed lane and extend it to a full word.
    always_comb begin
        load_byte = MemReadData_MEM[7:0];
        case (ByteAddr_MEM)
            2'd1:    load_byte = MemReadData_MEM[15:8];
            2'd2:    load_byte = MemReadData_MEM[23:16];
            2'd3:    load_byte = MemReadData_MEM[31:24];
            default: load_byte = MemReadData_MEM[7:0];
        endcase
        // Only address bit 1 matters for halves; odd addresses are not trapped.
        load_half = ByteAddr_MEM[1] ? MemReadData_MEM[31:16] : MemReadData_MEM[15:0];
        case (R_Width_MEM)
            2'b01:   load_ext = {{16{LoadSigned_MEM & load_half[15]}}, load_half};
            2'b10:   load_ext = {{24{LoadSigned_MEM & load_byte[7]}}, load_byte};
            default: load_ext = MemReadData_MEM;
        endcase
    end

    // Build the next WB contents; an invalid slot becomes an all-zero bubble.
    always_comb begin
        wb_nxt = '0;
        if (Valid_MEM) begin
            wb_nxt.vld  = 1'b1;
            wb_nxt.wr   = RegWrite_MEM && !(SUPPRESS_R0 && (RegDestSelected_MEM == 5'd0));
            wb_nxt.dest = RegDestSelected_MEM;
            wb_nxt.dat  = MemToReg_MEM ? load_ext : ALUResult_MEM;
        end
    end

    // WB register: reset > flush > stall > load.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wb_q <= '0;
        end else if (Flush_MEM) begin
            wb_q <= '0;
        end else if (!Stall_MEM) begin
            wb_q <= wb_nxt;
        end
    end

    assign Valid_WB           = wb_q.vld;
    assign regWrite_WB        = wb_q.wr;
    assign RegDestSelected_WB = wb_q.dest;
    assign regWriteData_WB    = wb_q.dat;

`ifdef RETIRE_COUNTER_EN
    logic [COUNT_WIDTH-1:0] retire_cnt;

    // Count every valid instruction that actually advances into WB, writer or not.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            retire_cnt <= '0;
        end else if (!Flush_MEM && !Stall_MEM && Valid_MEM) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

    assign RetireCount = retire_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: reset, ALU/load writeback, r0 suppression, stall/flush, optional retire counter.
// Latency checked: outputs sampled 1 ns after the edge that loads them.
// Backpressure: stall holds and stall+flush bubbles are exercised explicitly.
module tb_mem_wb_writeback;

    logic        Clock;
    logic        Reset;
    logic        Stall_MEM;
    logic        Flush_MEM;
    logic        Valid_MEM;
    logic        RegWrite_MEM;
    logic        MemToReg_MEM;
    logic [1:0]  R_Width_MEM;
    logic        LoadSigned_MEM;
    logic [1:0]  ByteAddr_MEM;
    logic [31:0] ALUResult_MEM;
    logic [31:0] MemReadData_MEM;
    logic [4:0]  RegDestSelected_MEM;
    logic [4:0]  RegDestSelected_WB;
    logic [31:0] regWriteData_WB;
    logic        regWrite_WB;
    logic        Valid_WB;
`ifdef RETIRE_COUNTER_EN
    logic [3:0]  RetireCount;
`endif

    int checks   = 0;
    int failures = 0;

    mem_wb_writeback #(
        .COUNT_WIDTH (4),
        .SUPPRESS_R0 (1'b1)
    ) dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .Stall_MEM           (Stall_MEM),
        .Flush_MEM           (Flush_MEM),
        .Valid_MEM           (Valid_MEM),
        .RegWrite_MEM        (RegWrite_MEM),
        .MemToReg_MEM        (MemToReg_MEM),
        .R_Width_MEM         (R_Width_MEM),
        .LoadSigned_MEM      (LoadSigned_MEM),
        .ByteAddr_MEM        (ByteAddr_MEM),
        .ALUResult_MEM       (ALUResult_MEM),
        .MemReadData_MEM     (MemReadData_MEM),
        .RegDestSelected_MEM (RegDestSelected_MEM),
        .RegDestSelected_WB  (RegDestSelected_WB),
        .regWriteData_WB     (regWriteData_WB),
        .regWrite_WB         (regWrite_WB),
        .Valid_WB            (Valid_WB)
`ifdef RETIRE_COUNTER_EN
        ,
        .RetireCount         (RetireCount)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drive one MEM-stage slot.
    task automatic drive(input logic vld, input logic rw, input logic m2r, input logic [1:0] width,
                         input logic sgn, input logic [1:0] ba, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [4:0] dest);
        Valid_MEM           = vld;
        RegWrite_MEM        = rw;
        MemToReg_MEM        = m2r;
        R_Width_MEM         = width;
        LoadSigned_MEM      = sgn;
        ByteAddr_MEM        = ba;
        ALUResult_MEM       = alu;
        MemReadData_MEM     = rd;
        RegDestSelected_MEM = dest;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic vld, input logic wr,
                           input logic [4:0] dest, input logic [31:0] dat);
        chk({tag, "_vld"},  {31'd0, Valid_WB}, {31'd0, vld});
        chk({tag, "_wr"},   {31'd0, regWrite_WB}, {31'd0, wr});
        chk({tag, "_dest"}, {27'd0, RegDestSelected_WB}, {27'd0, dest});
        chk({tag, "_dat"},  regWriteData_WB, dat);
    endtask

    localparam logic [31:0] LD = 32'h80FF_7F01;

    initial begin
        Reset = 1'b0;
        Stall_MEM = 1'b0;
        Flush_MEM = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h1111_1111, 32'h0, 5'd3);
        #12;
        chk_all("reset", 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge Clock);
        #1;
        Reset = 1'b1;

        // ALU result writeback
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0000_1234, LD, 5'd8);
        step();
        chk_all("alu", 1'b1, 1'b1, 5'd8, 32'h0000_1234);

        // Load extraction
        drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 2'd3, 32'hDEAD_BEEF, LD, 5'd9);
        step();
        chk_all("lb_s_3", 1'b1, 1'b1, 5'd9, 32'hFFFF_FF80);
        drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'd1, 32'hDEAD_BEEF, LD, 5'd10);
        step();
        chk("lbu_1", regWriteData_WB, 32'h0000_007F);
        drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 2'd2, 32'hDEAD_BEEF, LD, 5'd11);
        step();
        chk("lh_s_2", regWriteData_WB, 32'hFFFF_80FF);
        drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'd0, 32'hDEAD_BEEF, LD, 5'd12);
        step();
        chk("lhu_0", regWriteData_WB, 32'h0000_7F01);
        drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 2'd2, 32'hDEAD_BEEF, LD, 5'd13);
        step();
        chk("lw", regWriteData_WB, 32'h80FF_7F01);
        drive(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 2'd1, 32'hDEAD_BEEF, LD, 5'd13);
        step();
        chk("lw_11", regWriteData_WB, 32'h80FF_7F01);
        drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 2'd3, 32'hDEAD_BEEF, LD, 5'd14);
        step();
        chk("lh_s_3", regWriteData_WB, 32'hFFFF_80FF);

        // Non-writing instruction still carries data
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0000_0055, LD, 5'd4);
        step();
        chk_all("nowr", 1'b1, 1'b0, 5'd4, 32'h0000_0055);

        // Write to r0 is suppressed but stays valid
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0000_0077, LD, 5'd0);
        step();
        chk_all("r0", 1'b1, 1'b0, 5'd0, 32'h0000_0077);

        // Invalid slot becomes a bubble
        drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0000_0099, LD, 5'd7);
        step();
        chk_all("inval", 1'b0, 1'b0, 5'd0, 32'h0);

        // Stall holds, stall+flush bubbles
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0000_000A, LD, 5'd5);
        step();
        chk_all("pre_stall", 1'b1, 1'b1, 5'd5, 32'h0000_000A);
        Stall_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h100 + i, LD, 5'(20 + i));
            step();
            chk_all("stall", 1'b1, 1'b1, 5'd5, 32'h0000_000A);
        end
        Flush_MEM = 1'b1;
        step();
        chk_all("flush", 1'b0, 1'b0, 5'd0, 32'h0);
        Stall_MEM = 1'b0;
        Flush_MEM = 1'b0;

        // Asynchronous reset mid-operation
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0000_0ABC, LD, 5'd6);
        step();
        chk_all("pre_rst", 1'b1, 1'b1, 5'd6, 32'h0000_0ABC);
        #2;
        Reset = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk_all("rst_hold", 1'b0, 1'b0, 5'd0, 32'h0);
        Reset = 1'b1;
        step();
        chk_all("post_rst", 1'b1, 1'b1, 5'd6, 32'h0000_0ABC);

`ifdef RETIRE_COUNTER_EN
        // Fresh counter: 10 loads, 2 stalls, 1 flush, then 6 more to wrap
        Reset = 1'b0;
        #1;
        chk("cnt_rst", {28'd0, RetireCount}, 32'd0);
        step();
        Reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h1, LD, 5'd1);
        for (int i = 0; i < 10; i++) step();
        Stall_MEM = 1'b1;
        step();
        step();
        Stall_MEM = 1'b0;
        Flush_MEM = 1'b1;
        step();
        Flush_MEM = 1'b0;
        chk("cnt_10", {28'd0, RetireCount}, 32'd10);
        for (int i = 0; i < 6; i++) step();
        chk("cnt_wrap", {28'd0, RetireCount}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
